cordic_engine: RTL and testbench

Pipelined, parametrised CORDIC unit that handles both rotation and vectoring modes on a per-sample basis. It carries a per-sample tag and uses a valid/ready handshake with full-pipeline backpressure. It widens the datapath so that full-scale inputs cannot overflow. It sits between the sample sources and the DSP consumers (mixers, phase detectors, magnitude estimators) and replaces the fixed-width, free-running rotator.

---
 rtl/cordic_engine.sv | 175 +++++++++++++++++
 tb/tb_cordic_engine.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_engine.sv
// Pipelined CORDIC engine: per-sample rotation/vectoring, tag passthrough, and
// one global advance enable so a stalled output freezes every stage together.
module cordic_engine #(
    parameter int XY_SZ = 16,
    parameter int STG   = 16,
    parameter int TAG_W = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic signed [XY_SZ-1:0] in_x,
    input  logic signed [XY_SZ-1:0] in_y,
    input  logic [31:0]             in_z,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_mode,
    output logic signed [XY_SZ+1:0] out_x,
    output logic signed [XY_SZ+1:0] out_y,
    output logic [31:0]             out_z,
    output logic [TAG_W-1:0]        out_tag
);
    localparam int W = XY_SZ + 2;

    // atan(2^-i) with the full circle scaled to 2^32
    function automatic logic [31:0] atan_lut(input int i);
        case (i)
            0:  atan_lut = 32'd536870912;
            1:  atan_lut = 32'd316933406;
            2:  atan_lut = 32'd167458907;
            3:  atan_lut = 32'd85004756;
            4:  atan_lut = 32'd42667331;
            5:  atan_lut = 32'd21354465;
            6:  atan_lut = 32'd10679838;
            7:  atan_lut = 32'd5340245;
            8:  atan_lut = 32'd2670163;
            9:  atan_lut = 32'd1335087;
            10: atan_lut = 32'd667544;
            11: atan_lut = 32'd333772;
            12: atan_lut = 32'd166886;
            13: atan_lut = 32'd83443;
            14: atan_lut = 32'd41722;
            15: atan_lut = 32'd20861;
            16: atan_lut = 32'd10430;
            17: atan_lut = 32'd5215;
            18: atan_lut = 32'd2608;
            19: atan_lut = 32'd1304;
            20: atan_lut = 32'd652;
            21: atan_lut = 32'd326;
            22: atan_lut = 32'd163;
            23: atan_lut = 32'd81;
            24: atan_lut = 32'd41;
            25: atan_lut = 32'd20;
            26: atan_lut = 32'd10;
            27: atan_lut = 32'd5;
            28: atan_lut = 32'd3;
            29: atan_lut = 32'd1;
            30: atan_lut = 32'd1;
            default: atan_lut = 32'd0;
        endcase
    endfunction

    logic                adv;
    logic                v_q [STG];
    logic                m_q [STG];
    logic signed [W-1:0] x_q [STG];
    logic signed [W-1:0] y_q [STG];
    logic [31:0]         z_q [STG];
    logic [TAG_W-1:0]    t_q [STG];

    logic                v_d [STG];
    logic                m_d [STG];
    logic signed [W-1:0] x_d [STG];
    logic signed [W-1:0] y_d [STG];
    logic [31:0]         z_d [STG];
    logic [TAG_W-1:0]    t_d [STG];

    // widen before any negation so the most negative input negates exactly
    logic signed [W-1:0] xe, ye;
    logic signed [W-1:0] pre_x, pre_y;
    logic [31:0]         pre_z;

    assign xe = {{2{in_x[XY_SZ-1]}}, in_x};
    assign ye = {{2{in_y[XY_SZ-1]}}, in_y};

    assign adv      = ~v_q[STG-1] | out_ready;
    assign in_ready = adv;

    always_comb begin
        pre_x = xe;
        pre_y = ye;
        pre_z = in_z;
        if (!in_mode) begin
            case (in_z[31:30])
                2'b01: begin
                    pre_x = -ye;
                    pre_y = xe;
                    pre_z = {2'b00, in_z[29:0]};
                end
                2'b10: begin
                    pre_x = ye;
                    pre_y = -xe;
                    pre_z = {2'b11, in_z[29:0]};
                end
                default: ;
            endcase
        end else if (xe[W-1]) begin
            if (!ye[W-1]) begin
                pre_x = ye;
                pre_y = -xe;
                pre_z = in_z + 32'h4000_0000;
            end else begin
                pre_x = -ye;
                pre_y = xe;
                pre_z = in_z - 32'h4000_0000;
            end
        end
    end

    always_comb begin
        v_d[0] = in_valid & adv;
        m_d[0] = in_mode;
        x_d[0] = pre_x;
        y_d[0] = pre_y;
        z_d[0] = pre_z;
        t_d[0] = in_tag;
        // stage k runs iteration k-1; rotation steers z to 0, vectoring steers y to 0
        for (int k = 1; k < STG; k++) begin
            v_d[k] = v_q[k-1];
            m_d[k] = m_q[k-1];
            t_d[k] = t_q[k-1];
            if (m_q[k-1] ? y_q[k-1][W-1] : ~z_q[k-1][31]) begin
                x_d[k] = x_q[k-1] - (y_q[k-1] >>> (k-1));
                y_d[k] = y_q[k-1] + (x_q[k-1] >>> (k-1));
                z_d[k] = z_q[k-1] - atan_lut(k-1);
            end else begin
                x_d[k] = x_q[k-1] + (y_q[k-1] >>> (k-1));
                y_d[k] = y_q[k-1] - (x_q[k-1] >>> (k-1));
                z_d[k] = z_q[k-1] + atan_lut(k-1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STG; k++) begin
                v_q[k] <= 1'b0;
                m_q[k] <= 1'b0;
                x_q[k] <= '0;
                y_q[k] <= '0;
                z_q[k] <= '0;
                t_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STG; k++) begin
                v_q[k] <= v_d[k];
                m_q[k] <= m_d[k];
                x_q[k] <= x_d[k];
                y_q[k] <= y_d[k];
                z_q[k] <= z_d[k];
                t_q[k] <= t_d[k];
            end
        end
    end

    assign out_valid = v_q[STG-1];
    assign out_mode  = m_q[STG-1];
    assign out_x     = x_q[STG-1];
    assign out_y     = y_q[STG-1];
    assign out_z     = z_q[STG-1];
    assign out_tag   = t_q[STG-1];

endmodule

// File: tb/tb_cordic_engine.sv
// Directed bench for cordic_engine: latency, known-angle results, full scale,
// random backpressure ordering, and asynchronous mid-stream reset.
module tb_cordic_engine;
    localparam int XY_SZ = 16;
    localparam int STG   = 16;
    localparam int TAG_W = 4;

    logic                    clock = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic                    in_mode = 1'b0;
    logic signed [XY_SZ-1:0] in_x = '0;
    logic signed [XY_SZ-1:0] in_y = '0;
    logic [31:0]             in_z = '0;
    logic [TAG_W-1:0]        in_tag = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic                    out_mode;
    logic signed [XY_SZ+1:0] out_x;
    logic signed [XY_SZ+1:0] out_y;
    logic [31:0]             out_z;
    logic [TAG_W-1:0]        out_tag;

    int passed = 0;
    int total  = 0;

    cordic_engine #(.XY_SZ(XY_SZ), .STG(STG), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_tag(out_tag)
    );

    always #5 clock = ~clock;

    // issue one sample at posedge+1 and wait (bounded) for its result
    task automatic send_one(input logic m, input logic signed [15:0] x, input logic signed [15:0] y,
                            input logic [31:0] z, input logic [3:0] tag, output int lat);
        out_ready = 1'b1;
        in_mode = m; in_x = x; in_y = y; in_z = z; in_tag = tag;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({out_valid, out_mode, out_x, out_y, out_z, out_tag} !== '0)
            $display("FAIL reset_outputs: got v=%0d x=%0d y=%0d z=%h tag=%0d, want all 0",
                     out_valid, out_x, out_y, out_z, out_tag);
        else passed++;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release: got in_ready=%0d out_valid=%0d, want 1/0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_rotation();
        int lat;
        send_one(1'b0, 16'sd10000, 16'sd0, 32'h0, 4'h5, lat);
        total++;
        if (lat !== STG-1) $display("FAIL rot0_latency: got %0d, want %0d", lat, STG-1);
        else passed++;
        total++;
        if (int'(out_x) - 16468 > 4 || int'(out_x) - 16468 < -4)
            $display("FAIL rot0_x: got %0d, want 16468+-4", out_x);
        else passed++;
        total++;
        if (int'(out_y) > 4 || int'(out_y) < -4) $display("FAIL rot0_y: got %0d, want 0+-4", out_y);
        else passed++;
        total++;
        if (out_tag !== 4'h5 || out_mode !== 1'b0)
            $display("FAIL rot0_tag: got tag=%0d mode=%0d, want 5/0", out_tag, out_mode);
        else passed++;
    endtask

    task automatic test_vectoring();
        int lat;
        send_one(1'b1, -16'sd10000, 16'sd0, 32'h0, 4'h9, lat);
        total++;
        if (lat !== STG-1 || out_tag !== 4'h9 || out_mode !== 1'b1)
            $display("FAIL vec180_meta: got lat=%0d tag=%0d mode=%0d, want %0d/9/1", lat, out_tag, out_mode, STG-1);
        else passed++;
        total++;
        if ($signed(out_z - 32'h8000_0000) > 262144 || $signed(out_z - 32'h8000_0000) < -262144)
            $display("FAIL vec180_z: got %h, want 80000000+-2^18", out_z);
        else passed++;
        total++;
        if (int'(out_x) - 16468 > 4 || int'(out_x) - 16468 < -4)
            $display("FAIL vec180_x: got %0d, want 16468+-4", out_x);
        else passed++;
    endtask

    task automatic test_full_scale();
        int lat;
        send_one(1'b1, 16'sh8000, 16'sh8000, 32'h0, 4'hC, lat);
        total++;
        if (lat !== STG-1) $display("FAIL fs_latency: got %0d, want %0d", lat, STG-1);
        else passed++;
        total++;
        if (int'(out_x) - 76310 > 6 || int'(out_x) - 76310 < -6)
            $display("FAIL fs_x: got %0d, want 76310+-6", out_x);
        else passed++;
        total++;
        if (int'(out_y) > 6 || int'(out_y) < -6) $display("FAIL fs_y: got %0d, want 0+-6", out_y);
        else passed++;
        total++;
        if ($signed(out_z - 32'hA000_0000) > 262144 || $signed(out_z - 32'hA000_0000) < -262144)
            $display("FAIL fs_z: got %h, want a0000000+-2^18", out_z);
        else passed++;
    endtask

    // rotation +90, vectoring 45 deg and rotation -90 issued on consecutive cycles
    task automatic test_back_to_back();
        int w;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_mode = 1'b0; in_x = 16'sd10000; in_y = 16'sd0; in_z = 32'h4000_0000; in_tag = 4'h1;
        @(posedge clock); #1;
        in_mode = 1'b1; in_x = 16'sd10000; in_y = 16'sd10000; in_z = 32'h0; in_tag = 4'h2;
        @(posedge clock); #1;
        in_mode = 1'b0; in_x = 16'sd10000; in_y = 16'sd0; in_z = 32'hC000_0000; in_tag = 4'h3;
        @(posedge clock); #1;
        in_valid = 1'b0;
        w = 2;
        while (!out_valid && w < 40) begin
            @(posedge clock); #1;
            w++;
        end
        total++;
        if (w !== STG-1) $display("FAIL b2b_latency: got %0d, want %0d", w, STG-1);
        else passed++;
        total++;
        if (out_tag !== 4'h1 || out_mode !== 1'b0 || int'(out_x) > 4 || int'(out_x) < -4
            || int'(out_y) - 16468 > 4 || int'(out_y) - 16468 < -4)
            $display("FAIL rot90: got tag=%0d mode=%0d x=%0d y=%0d, want 1/0 0 16468", out_tag, out_mode, out_x, out_y);
        else passed++;
        @(posedge clock); #1;
        total++;
        if (out_valid !== 1'b1 || out_tag !== 4'h2 || out_mode !== 1'b1
            || int'(out_x) - 23288 > 4 || int'(out_x) - 23288 < -4 || int'(out_y) > 4 || int'(out_y) < -4)
            $display("FAIL vec45_xy: got v=%0d tag=%0d x=%0d y=%0d, want 1 2 23288 0", out_valid, out_tag, out_x, out_y);
        else passed++;
        total++;
        if ($signed(out_z - 32'h2000_0000) > 262144 || $signed(out_z - 32'h2000_0000) < -262144)
            $display("FAIL vec45_z: got %h, want 20000000+-2^18", out_z);
        else passed++;
        @(posedge clock); #1;
        total++;
        if (out_valid !== 1'b1 || out_tag !== 4'h3 || int'(out_x) > 4 || int'(out_x) < -4
            || int'(out_y) + 16468 > 4 || int'(out_y) + 16468 < -4)
            $display("FAIL rotm90: got v=%0d tag=%0d x=%0d y=%0d, want 1 3 0 -16468", out_valid, out_tag, out_x, out_y);
        else passed++;
        @(posedge clock); #1;
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int r;
        logic acc, ret, stalled;
        logic [TAG_W:0] expq[$];
        logic [TAG_W:0] e;
        logic [2*(XY_SZ+2)+32+TAG_W+1:0] snap;
        stalled = 1'b0;
        snap = '0;
        in_valid = 1'b0;
        while (got < 40 && cyc < 2000) begin
            if (stalled) begin
                total++;
                if ({out_valid, out_mode, out_x, out_y, out_z, out_tag} !== snap)
                    $display("FAIL bp_hold: outputs changed while stalled, got tag=%0d x=%0d", out_tag, out_x);
                else passed++;
            end
            if (!in_valid && sent < 40) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_mode = 1'($urandom_range(0, 1));
                r = int'($urandom_range(0, 40000)) - 20000;
                in_x = r[15:0];
                r = int'($urandom_range(0, 40000)) - 20000;
                in_y = r[15:0];
                in_z = $urandom();
                in_tag = sent[3:0];
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (in_ready !== (~out_valid | out_ready))
                $display("FAIL bp_in_ready: got %0d, want %0d", in_ready, ~out_valid | out_ready);
            else passed++;
            acc = in_valid && in_ready;
            ret = out_valid && out_ready;
            if (ret) begin
                total++;
                if (expq.size() == 0) begin
                    $display("FAIL bp_extra: got unexpected result tag=%0d, want none", out_tag);
                end else begin
                    e = expq.pop_front();
                    if ({out_tag, out_mode} !== e)
                        $display("FAIL bp_order: got tag=%0d mode=%0d, want tag=%0d mode=%0d",
                                 out_tag, out_mode, e[TAG_W:1], e[0]);
                    else passed++;
                end
                got++;
            end
            if (acc) begin
                expq.push_back({in_tag, in_mode});
                sent++;
            end
            stalled = out_valid && !out_ready;
            snap = {out_valid, out_mode, out_x, out_y, out_z, out_tag};
            @(posedge clock); #1;
            cyc++;
            if (acc) in_valid = 1'b0;
        end
        total++;
        if (got !== 40 || expq.size() != 0)
            $display("FAIL bp_count: got %0d results (%0d pending), want 40 (0)", got, expq.size());
        else passed++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (STG + 2) @(posedge clock);
        #1;
    endtask

    task automatic test_mid_reset();
        int early = 0;
        int bad = 0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 1'b0; in_x = 16'sd10000; in_y = 16'sd0; in_z = 32'h0; in_tag = 4'h3;
        repeat (20) @(posedge clock);
        #1;
        total++;
        if (out_valid !== 1'b1 || out_tag !== 4'h3)
            $display("FAIL mr_pre: got v=%0d tag=%0d, want 1/3", out_valid, out_tag);
        else passed++;
        #2;
        reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if ({out_valid, out_mode, out_x, out_y, out_z, out_tag} !== '0)
            $display("FAIL mr_async_clear: got v=%0d x=%0d tag=%0d, want all 0", out_valid, out_x, out_tag);
        else passed++;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        in_valid = 1'b1; in_mode = 1'b1; in_x = 16'sd1000; in_y = 16'sd500; in_z = 32'h0; in_tag = 4'hC;
        for (int k = 1; k <= STG; k++) begin
            @(posedge clock); #1;
            if (k < STG && out_valid) early++;
        end
        total++;
        if (early !== 0) $display("FAIL mr_early_valid: got %0d valid cycles, want 0", early);
        else passed++;
        total++;
        if (out_valid !== 1'b1 || out_tag !== 4'hC)
            $display("FAIL mr_first_post: got v=%0d tag=%0d, want 1/12", out_valid, out_tag);
        else passed++;
        in_valid = 1'b0;
        repeat (STG + 2) begin
            if (out_valid && out_tag !== 4'hC) bad++;
            @(posedge clock); #1;
        end
        total++;
        if (bad !== 0) $display("FAIL mr_stale: got %0d pre-reset results, want 0", bad);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_vectoring();
        test_full_scale();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
